// File: rtl/sram_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its three requesters and the external SRAM pins.
// The arbiter takes the slave view; requesters and the SRAM model take the master view.
interface sram_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 8
);
  logic          ldReq;
  logic [AW-1:0] ldA;
  logic [DW-1:0] ldD;
  logic          ldAck;

  logic          vReq;
  logic [AW-1:0] vA;
  logic [DW-1:0] vQ;
  logic          vAck;

  logic          cReq;
  logic          cWe;
  logic [AW-1:0] cA;
  logic [DW-1:0] cD;
  logic [DW-1:0] cQ;
  logic          cAck;

  logic [AW-1:0] sramA;
  logic [DW-1:0] sramDo;
  logic [DW-1:0] sramDi;
  logic          sramDoe;
  logic          sramOe;
  logic          sramWe;

  modport slave (
    input  ldReq, ldA, ldD, vReq, vA, cReq, cWe, cA, cD, sramDi,
    output ldAck, vQ, vAck, cQ, cAck, sramA, sramDo, sramDoe, sramOe, sramWe
  );

  modport master (
    output ldReq, ldA, ldD, vReq, vA, cReq, cWe, cA, cD, sramDi,
    input  ldAck, vQ, vAck, cQ, cAck, sramA, sramDo, sramDoe, sramOe, sramWe
  );
endinterface

// File: rtl/sram_arbiter.sv
// Three-way arbiter (loader > video > CPU, with a video starvation guard) in front of one
// asynchronous SRAM; every access is a fixed IDLE -> ACC1 -> ACC2 sequence.
module sram_arbiter #(
  parameter int AW = 19,
  parameter int DW = 8
) (
  input  logic           clock,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACC1, ACC2} state_t;
  typedef enum logic [1:0] {OWN_LD, OWN_V, OWN_C} own_t;

  state_t        state, state_nx;
  own_t          own_q, own_nx;
  logic          grant;
  logic [AW-1:0] a_q, a_nx;
  logic [DW-1:0] d_q, d_nx;
  logic          we_q, we_nx;
  logic [1:0]    vcnt;
  logic [2:0]    ack_q;
  logic [DW-1:0] vq_q, cq_q;

  // Arbitration: CPU jumps ahead of video once two video grants in a row happened while it waited.
  always_comb begin
    grant  = 1'b0;
    own_nx = own_q;
    a_nx   = a_q;
    d_nx   = d_q;
    we_nx  = we_q;
    if (state == IDLE) begin
      if (bus.ldReq) begin
        grant = 1'b1; own_nx = OWN_LD; a_nx = bus.ldA; d_nx = bus.ldD; we_nx = 1'b1;
      end else if (bus.cReq && (!bus.vReq || vcnt == 2'd2)) begin
        grant = 1'b1; own_nx = OWN_C; a_nx = bus.cA; we_nx = bus.cWe;
        if (bus.cWe) d_nx = bus.cD;
      end else if (bus.vReq) begin
        grant = 1'b1; own_nx = OWN_V; a_nx = bus.vA; we_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = grant ? ACC1 : IDLE;
      ACC1:    state_nx = ACC2;
      ACC2:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.sramA   = a_q;
    bus.sramDo  = d_q;
    bus.sramDoe = we_q && (state != IDLE);
    bus.sramWe  = !(we_q && (state == ACC1));
    bus.sramOe  = !(!we_q && (state != IDLE));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      own_q <= OWN_LD;
      a_q   <= '0;
      d_q   <= '0;
      we_q  <= 1'b0;
    end else if (grant) begin
      own_q <= own_nx;
      a_q   <= a_nx;
      d_q   <= d_nx;
      we_q  <= we_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset)                       vcnt <= 2'd0;
    else if (!bus.cReq)               vcnt <= 2'd0;
    else if (grant && own_nx == OWN_C) vcnt <= 2'd0;
    else if (grant && own_nx == OWN_V && vcnt != 2'd2) vcnt <= vcnt + 2'd1;
  end

  // Ack and read data land together on the edge that closes ACC2.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ack_q <= '0;
      vq_q  <= '0;
      cq_q  <= '0;
    end else begin
      ack_q <= '0;
      if (state == ACC2) begin
        case (own_q)
          OWN_LD:  ack_q[0] <= 1'b1;
          OWN_V:   ack_q[1] <= 1'b1;
          OWN_C:   ack_q[2] <= 1'b1;
          default: ack_q <= '0;
        endcase
        if (!we_q && own_q == OWN_V) vq_q <= bus.sramDi;
        if (!we_q && own_q == OWN_C) cq_q <= bus.sramDi;
      end
    end
  end

  assign bus.ldAck = ack_q[0];
  assign bus.vAck  = ack_q[1];
  assign bus.cAck  = ack_q[2];
  assign bus.vQ    = vq_q;
  assign bus.cQ    = cq_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized + directed bench for sram_arbiter against a transaction-level model
// that is compared on every falling edge.
module tb_sram_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sram_arbiter #(.AW(AW), .DW(DW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int vecs = 0;
  int errs = 0;

  // SRAM content is a pure function of address; outside the capture cycle the bus carries garbage.
  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h83;
  endfunction

  logic acc2 = 1'b0;
  assign bus.sramDi = acc2 ? f(bus.sramA) : ~f(bus.sramA);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_str(input string nm, input string act, input string exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
    end
  endtask

  // Model: an access occupies two busy cycles after its grant, then acks in the following idle cycle.
  int            m_left = 0;
  int            m_own  = 0;
  int            m_cnt  = 0;
  logic [AW-1:0] m_a    = '0;
  logic [DW-1:0] m_d    = '0;
  logic          m_we   = 1'b0;
  logic [2:0]    m_ack  = '0;
  logic [DW-1:0] m_vq   = '0;
  logic [DW-1:0] m_cq   = '0;

  always @(posedge clock) begin
    if (!reset) begin
      m_left = 0; m_own = 0; m_cnt = 0; m_a = '0; m_d = '0; m_we = 1'b0;
      m_ack = '0; m_vq = '0; m_cq = '0;
    end else begin
      m_ack = '0;
      if (m_left == 2) m_left = 1;
      else if (m_left == 1) begin
        m_left = 0;
        m_ack[m_own] = 1'b1;
        if (!m_we && m_own == 1) m_vq = f(m_a);
        if (!m_we && m_own == 2) m_cq = f(m_a);
      end else begin
        if (bus.ldReq) begin
          m_own = 0; m_a = bus.ldA; m_d = bus.ldD; m_we = 1'b1; m_left = 2;
        end else if (bus.cReq && (!bus.vReq || m_cnt >= 2)) begin
          m_own = 2; m_a = bus.cA; m_we = bus.cWe; m_left = 2; m_cnt = 0;
          if (bus.cWe) m_d = bus.cD;
        end else if (bus.vReq) begin
          m_own = 1; m_a = bus.vA; m_we = 1'b0; m_left = 2; m_cnt++;
        end
      end
      if (!bus.cReq) m_cnt = 0;
    end
  end

  always @(negedge clock) begin
    check("sramA",   32'(bus.sramA),   32'(m_a));
    check("sramDo",  32'(bus.sramDo),  32'(m_d));
    check("sramDoe", 32'(bus.sramDoe), 32'(m_left > 0 && m_we));
    check("sramWe",  32'(bus.sramWe),  32'(!(m_left == 2 && m_we)));
    check("sramOe",  32'(bus.sramOe),  32'(!(m_left > 0 && !m_we)));
    check("acks",    32'({bus.cAck, bus.vAck, bus.ldAck}), 32'(m_ack));
    check("vQ",      32'(bus.vQ),      32'(m_vq));
    check("cQ",      32'(bus.cQ),      32'(m_cq));
    acc2 = (m_left == 1);
  end

  string ack_log;
  int    ts[$];
  int    tick;

  task automatic run_log(input int cyc, input bit keep);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clock);
      tick++;
      if (bus.ldAck) begin ack_log = {ack_log, "L"}; ts.push_back(tick); bus.ldReq = 1'b0; end
      if (bus.vAck) begin
        ack_log = {ack_log, "V"}; ts.push_back(tick);
        if (keep) bus.vA = AW'($urandom); else bus.vReq = 1'b0;
      end
      if (bus.cAck) begin
        ack_log = {ack_log, "C"}; ts.push_back(tick);
        if (keep) bus.cA = AW'($urandom); else bus.cReq = 1'b0;
      end
    end
  endtask

  initial begin
    int n, oe_lo, doe_hi, cnt;
    bit got;
    bus.ldReq = 1'b0; bus.ldA = '0; bus.ldD = '0;
    bus.vReq = 1'b0; bus.vA = '0;
    bus.cReq = 1'b0; bus.cWe = 1'b0; bus.cA = '0; bus.cD = '0;
    repeat (3) @(negedge clock);
    check("rst_oe",  32'(bus.sramOe), 'h1);
    check("rst_we",  32'(bus.sramWe), 'h1);
    check("rst_doe", 32'(bus.sramDoe), 'h0);
    check("rst_A",   32'(bus.sramA), 'h0);
    reset = 1'b1;
    @(negedge clock);

    // Single CPU read
    bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 19'h01234;
    n = 0; oe_lo = 0; doe_hi = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock); n++;
      if (!bus.sramOe) oe_lo++;
      if (bus.sramDoe) doe_hi++;
      if (bus.cAck) got = 1'b1;
    end
    bus.cReq = 1'b0;
    check("cpu_rd_lat", n, 'd3);
    check("cpu_rd_oe_cycles", oe_lo, 'd2);
    check("cpu_rd_doe", doe_hi, 'd0);
    check("cpu_rd_q", 32'(bus.cQ), 'hA5);
    @(negedge clock);

    // Loader write
    bus.ldReq = 1'b1; bus.ldA = 19'h40000; bus.ldD = 8'h3C;
    @(negedge clock);
    check("ld_acc1_we", 32'(bus.sramWe), 'h0);
    check("ld_acc1_doe", 32'(bus.sramDoe), 'h1);
    check("ld_acc1_do", 32'(bus.sramDo), 'h3C);
    check("ld_acc1_A", 32'(bus.sramA), 'h40000);
    @(negedge clock);
    check("ld_acc2_we", 32'(bus.sramWe), 'h1);
    check("ld_acc2_doe", 32'(bus.sramDoe), 'h1);
    check("ld_acc2_do", 32'(bus.sramDo), 'h3C);
    @(negedge clock);
    check("ld_ack", 32'(bus.ldAck), 'h1);
    bus.ldReq = 1'b0;
    @(negedge clock);
    check("ld_ack_once", 32'(bus.ldAck), 'h0);

    // All three at once
    bus.ldReq = 1'b1; bus.ldA = 19'h00100; bus.ldD = 8'h11;
    bus.vReq = 1'b1; bus.vA = 19'h00200;
    bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 19'h00300;
    ack_log = ""; ts.delete(); tick = 0;
    run_log(10, 1'b0);
    check_str("prio_order", ack_log, "LVC");
    if (ts.size() == 3) begin
      check("prio_gap1", ts[1] - ts[0], 'd3);
      check("prio_gap2", ts[2] - ts[1], 'd3);
    end else check("prio_ack_count", ts.size(), 'd3);

    // Starvation guard
    bus.vReq = 1'b1; bus.vA = 19'h01000;
    bus.cReq = 1'b1; bus.cWe = 1'b1; bus.cA = 19'h02000; bus.cD = 8'h5A;
    ack_log = ""; ts.delete(); tick = 0;
    run_log(18, 1'b1);
    bus.vReq = 1'b0; bus.cReq = 1'b0;
    check_str("starve_order", ack_log, "VVCVVC");
    repeat (2) @(negedge clock);

    // Reset during ACC1 of a CPU write, request held through reset
    bus.cReq = 1'b1; bus.cWe = 1'b1; bus.cA = 19'h03456; bus.cD = 8'h77;
    @(negedge clock);
    check("rmid_acc1_we", 32'(bus.sramWe), 'h0);
    reset = 1'b0;
    @(negedge clock);
    check("rmid_we", 32'(bus.sramWe), 'h1);
    check("rmid_doe", 32'(bus.sramDoe), 'h0);
    check("rmid_ack", 32'(bus.cAck), 'h0);
    reset = 1'b1;
    n = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clock); n++;
      if (bus.cAck) got = 1'b1;
    end
    bus.cReq = 1'b0;
    check("rmid_resume_lat", n, 'd3);
    check("rmid_cq", 32'(bus.cQ), 'h0);
    @(negedge clock);

    // One-cycle CPU pulse
    bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 19'h05555;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (i == 0) bus.cReq = 1'b0;
      if (bus.cAck) cnt++;
    end
    check("pulse_acks", cnt, 'd1);
    check("pulse_cq", 32'(bus.cQ), 32'(f(19'h05555)));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(299) == 0) reset = 1'b0;

      if (bus.ldAck && $urandom_range(1) == 0) bus.ldReq = 1'b0;
      else if ((bus.ldAck || !bus.ldReq) && $urandom_range(9) == 0) begin
        bus.ldReq = 1'b1; bus.ldA = AW'($urandom); bus.ldD = DW'($urandom);
      end else if (bus.ldReq && $urandom_range(31) == 0) bus.ldReq = 1'b0;

      if (bus.vAck && $urandom_range(2) == 0) bus.vReq = 1'b0;
      else if (bus.vAck || (!bus.vReq && $urandom_range(2) == 0)) begin
        bus.vReq = 1'b1; bus.vA = AW'($urandom);
      end else if (bus.vReq && $urandom_range(31) == 0) bus.vReq = 1'b0;

      if (bus.cAck && $urandom_range(1) == 0) bus.cReq = 1'b0;
      else if (bus.cAck || (!bus.cReq && $urandom_range(3) == 0)) begin
        bus.cReq = 1'b1; bus.cWe = 1'($urandom); bus.cA = AW'($urandom); bus.cD = DW'($urandom);
      end else if (bus.cReq && $urandom_range(31) == 0) bus.cReq = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
